// File: rtl/turn_timer_if.sv
// Bundles the turn timer's control inputs and display/status outputs.
// master: game-side driver of start/pause; slave: the timer itself.
interface turn_timer_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             pause;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             finished;
  logic             expired;

  modport master (
    output start, pause,
    input  count, running, finished, expired
  );

  modport slave (
    input  start, pause,
    output count, running, finished, expired
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn seconds timer: CLK_HZ prescaler feeding a seconds counter that stops at TIMEOUT_S.
// Optional macro TURN_TIMER_COUNTDOWN_EN makes count show remaining instead of elapsed seconds.
module turn_timer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_S = 15,
  parameter int unsigned CNT_W     = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  turn_timer_if.slave  bus
);

  localparam int unsigned      PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SEC_MAX    = CNT_W'(TIMEOUT_S);

`ifdef TURN_TIMER_COUNTDOWN_EN
  localparam logic [CNT_W-1:0] COUNT_RST  = SEC_MAX;
`else
  localparam logic [CNT_W-1:0] COUNT_RST  = '0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [PW-1:0]    r_presc, w_presc_d;
  logic [CNT_W-1:0] r_sec, w_sec_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_running, w_running_d;
  logic             r_finished, w_finished_d;
  logic             r_expired, w_expired_d;
  logic             w_tick;

  always_comb begin
    w_state_d   = r_state;
    w_presc_d   = r_presc;
    w_sec_d     = r_sec;
    w_expired_d = 1'b0;
    w_tick      = (r_presc == PRESC_LAST);

    if (bus.start) begin
      w_state_d = StRun;
      w_presc_d = '0;
      w_sec_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        // The cycle that leaves PAUSED already counts, so a pause costs exactly its length.
        StRun, StPaused: begin
          if (bus.pause) begin
            w_state_d = StPaused;
          end else begin
            w_state_d = StRun;
            if (w_tick) begin
              w_presc_d = '0;
              if (r_sec == SEC_LAST) begin
                w_sec_d     = SEC_MAX;
                w_state_d   = StDone;
                w_expired_d = 1'b1;
              end else begin
                w_sec_d = r_sec + 1'b1;
              end
            end else begin
              w_presc_d = r_presc + 1'b1;
            end
          end
        end
        StDone: ;
      endcase
    end

    w_running_d  = (w_state_d == StRun) || (w_state_d == StPaused);
    w_finished_d = (w_state_d == StDone);
`ifdef TURN_TIMER_COUNTDOWN_EN
    w_count_d    = SEC_MAX - w_sec_d;
`else
    w_count_d    = w_sec_d;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_presc    <= '0;
      r_sec      <= '0;
      r_count    <= COUNT_RST;
      r_running  <= 1'b0;
      r_finished <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_presc    <= w_presc_d;
      r_sec      <= w_sec_d;
      r_count    <= w_count_d;
      r_running  <= w_running_d;
      r_finished <= w_finished_d;
      r_expired  <= w_expired_d;
    end
  end

  assign bus.count    = r_count;
  assign bus.running  = r_running;
  assign bus.finished = r_finished;
  assign bus.expired  = r_expired;

endmodule

// File: tb/tb_turn_timer.sv
// Self-checking bench for turn_timer at CLK_HZ=4, TIMEOUT_S=3: table-driven basic run plus
// hand-written pause, restart, race, start+pause and asynchronous reset sequences.
module tb_turn_timer;

  localparam int unsigned CLK_HZ    = 4;
  localparam int unsigned TIMEOUT_S = 3;
  localparam int unsigned CNT_W     = 4;

  typedef struct {
    logic       start;
    logic       pause;
    logic [3:0] count;
    logic       running;
    logic       finished;
    logic       expired;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  turn_timer_if #(.CNT_W(CNT_W)) tif ();

  turn_timer #(
    .CLK_HZ   (CLK_HZ),
    .TIMEOUT_S(TIMEOUT_S),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (tif.slave)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t tbl[15];

  // Displayed value for a given number of elapsed seconds.
  function automatic logic [3:0] cval(input int s);
`ifdef TURN_TIMER_COUNTDOWN_EN
    return 4'(TIMEOUT_S - s);
`else
    return 4'(s);
`endif
  endfunction

  function automatic vec_t mk(input logic s, input logic p, input int sec,
                              input logic r, input logic f, input logic x);
    vec_t v;
    v.start = s; v.pause = p; v.count = cval(sec);
    v.running = r; v.finished = f; v.expired = x;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input vec_t e);
    chk({nm, ".count"},    int'(tif.count),    int'(e.count));
    chk({nm, ".running"},  int'(tif.running),  int'(e.running));
    chk({nm, ".finished"}, int'(tif.finished), int'(e.finished));
    chk({nm, ".expired"},  int'(tif.expired),  int'(e.expired));
  endtask

  // Drive one cycle of inputs, queue its expectation, compare just after the edge.
  task automatic step(input vec_t v, input string nm);
    vec_t e;
    tif.start = v.start;
    tif.pause = v.pause;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_outs(nm, e);
  endtask

  // k counts RUN cycles since the start edge; tick every CLK_HZ of them.
  task automatic run_active(input int k0, input int k1, input string nm);
    for (int k = k0; k <= k1; k++) step(mk(1'b0, 1'b0, k / CLK_HZ, 1'b1, 1'b0, 1'b0), nm);
  endtask

  task automatic finish_cycle(input string nm);
    step(mk(1'b0, 1'b0, TIMEOUT_S, 1'b0, 1'b1, 1'b1), nm);
    step(mk(1'b0, 1'b0, TIMEOUT_S, 1'b0, 1'b1, 1'b0), {nm, "_hold"});
  endtask

  task automatic async_reset(input string nm);
    #2 rst = 1'b1;
    #1 chk_outs(nm, mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) tbl[k] = mk(1'b0, 1'b0, k / CLK_HZ, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, TIMEOUT_S, 1'b0, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, TIMEOUT_S, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, TIMEOUT_S, 1'b0, 1'b1, 1'b0);

    tif.start = 1'b0;
    tif.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_outs("reset", mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    step(mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0), "idle");
    step(mk(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0), "idle_pause");

    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("basic[%0d]", i));

    // Pause for 5 cycles after count reaches 1; finish lands 5 cycles late.
    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "done_start");
    run_active(1, 4, "pz_run");
    repeat (5) step(mk(1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0), "pz_hold");
    run_active(5, 11, "pz_resume");
    finish_cycle("pz_finish");

    // Restart at count 2 gives a full 12 cycles again.
    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "rs_start");
    run_active(1, 8, "rs_run");
    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "restart");
    run_active(1, 11, "rs_again");
    finish_cycle("rs_finish");

    // Start on the final-tick cycle wins: no expired, finished stays low.
    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "race_start");
    run_active(1, 11, "race_run");
    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "race");
    run_active(1, 3, "race_after");

    // start+pause together restarts; pause still high then holds the timer.
    step(mk(1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0), "sp_start");
    repeat (4) step(mk(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0), "sp_hold");
    run_active(1, 11, "sp_run");
    finish_cycle("sp_finish");

    async_reset("arst_done");
    step(mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0), "arst_done_idle");

    step(mk(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0), "ar_start");
    run_active(1, 5, "ar_run");
    async_reset("arst_run");
    repeat (2) step(mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0), "arst_run_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
